// File: rtl/game_pkg.sv
// Shared screen geometry, sprite sizes, motion steps and the bullet state encoding
// used by the player, alien and collision blocks.
package game_pkg;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int PLAYER_W    = 32;
  localparam int PLAYER_Y    = 440;
  localparam int BULLET_H    = 8;
  localparam int PLAYER_STEP = 2;
  localparam int BULLET_STEP = 4;
  localparam int X_W         = 10;
  localparam int Y_W         = 10;

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } bullet_state_t;
endpackage

// File: rtl/bullet_unit.sv
// Single player bullet: fire-request latch, IDLE/FLYING FSM and registered bullet
// coordinates. Launch column comes from the caller's current (pre-move) player_x.
module bullet_unit
  import game_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic                        game_rst,
  input  logic                        shoot,
  input  logic                        bullet_hit,
  input  logic [game_pkg::X_W-1:0]    player_x,
  output logic [game_pkg::X_W-1:0]    bullet_x,
  output logic [game_pkg::Y_W-1:0]    bullet_y,
  output logic                        bullet_active,
  output logic                        fire_evt
);

  localparam logic [X_W-1:0] BX_OFS    = X_W'(PLAYER_W / 2);
  localparam logic [Y_W-1:0] BY_LAUNCH = Y_W'(PLAYER_Y - BULLET_H);
  localparam logic [Y_W-1:0] BY_STEP   = Y_W'(BULLET_STEP);

  bullet_state_t  state, state_nxt;
  logic           shoot_pending, pending_nxt;
  logic           launch;
  logic [X_W-1:0] bx_nxt;
  logic [Y_W-1:0] by_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A hit wins over a coincident tick; an off-screen tick leaves bullet_y as is.
  always_comb begin
    state_nxt = state;
    if (game_rst) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (tick && (shoot_pending || shoot)) state_nxt = FLYING;
        FLYING:  if (bullet_hit || (tick && bullet_y < BY_STEP)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    launch      = !game_rst && (state == IDLE) && tick && (shoot_pending || shoot);
    pending_nxt = shoot_pending;
    bx_nxt      = bullet_x;
    by_nxt      = bullet_y;
    if (game_rst) begin
      pending_nxt = 1'b0;
      bx_nxt      = '0;
      by_nxt      = '0;
    end else if (launch) begin
      pending_nxt = 1'b0;
      bx_nxt      = player_x + BX_OFS;
      by_nxt      = BY_LAUNCH;
    end else if (state == IDLE) begin
      if (shoot) pending_nxt = 1'b1;
    end else if (!bullet_hit && tick && bullet_y >= BY_STEP) begin
      by_nxt = bullet_y - BY_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shoot_pending <= 1'b0;
      bullet_x      <= '0;
      bullet_y      <= '0;
      fire_evt      <= 1'b0;
    end else begin
      shoot_pending <= pending_nxt;
      bullet_x      <= bx_nxt;
      bullet_y      <= by_nxt;
      fire_evt      <= launch;
    end
  end

  assign bullet_active = (state == FLYING);

endmodule

// File: rtl/player_ctrl.sv
// Player cannon: clamped horizontal movement on each frame tick, plus the bullet
// unit that launches from the cannon's centre.
module player_ctrl
  import game_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic                        game_rst,
  input  logic                        left,
  input  logic                        right,
  input  logic                        shoot,
  input  logic                        bullet_hit,
  output logic [game_pkg::X_W-1:0]    player_x,
  output logic [game_pkg::X_W-1:0]    bullet_x,
  output logic [game_pkg::Y_W-1:0]    bullet_y,
  output logic                        bullet_active,
  output logic                        fire_evt
);

  localparam logic [X_W-1:0] X_RESET = X_W'((SCREEN_W - PLAYER_W) / 2);
  localparam logic [X_W-1:0] X_MAX   = X_W'(SCREEN_W - PLAYER_W);
  localparam logic [X_W-1:0] X_STEP  = X_W'(PLAYER_STEP);

  // Compare before subtracting so the coordinate never wraps below zero.
  function automatic logic [X_W-1:0] step_left(input logic [X_W-1:0] x);
    return (x < X_STEP) ? '0 : x - X_STEP;
  endfunction

  // One extra bit of headroom so the sum is clamped before it can overflow.
  function automatic logic [X_W-1:0] step_right(input logic [X_W-1:0] x);
    logic [X_W:0] sum;
    sum = {1'b0, x} + {1'b0, X_STEP};
    return (sum > {1'b0, X_MAX}) ? X_MAX : sum[X_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         player_x <= X_RESET;
    else if (game_rst)               player_x <= X_RESET;
    else if (tick && (left ^ right)) player_x <= left ? step_left(player_x) : step_right(player_x);
  end

  bullet_unit u_bullet (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .game_rst      (game_rst),
    .shoot         (shoot),
    .bullet_hit    (bullet_hit),
    .player_x      (player_x),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .fire_evt      (fire_evt)
  );

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: directed scenarios plus random inputs, checked
// every cycle against a behavioural model of the cannon and its bullet.
module tb_player_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, game_rst = 1'b0, left = 1'b0, right = 1'b0;
  logic       shoot = 1'b0, bullet_hit = 1'b0;
  logic [9:0] player_x, bullet_x, bullet_y;
  logic       bullet_active, fire_evt;

  player_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .game_rst      (game_rst),
    .left          (left),
    .right         (right),
    .shoot         (shoot),
    .bullet_hit    (bullet_hit),
    .player_x      (player_x),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .fire_evt      (fire_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int px;
    int bx;
    int by;
    int act;
    int fire;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Behavioural model state
  int m_px = 304, m_bx = 0, m_by = 0, m_act = 0, m_fire = 0, m_pend = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and push the state expected after the next edge.
  task automatic cyc(input bit t, input bit l, input bit r, input bit s, input bit h, input bit g);
    bit   launch;
    exp_t e;
    @(negedge clk);
    tick = t; left = l; right = r; shoot = s; bullet_hit = h; game_rst = g;
    if (g) begin
      m_px = 304; m_bx = 0; m_by = 0; m_act = 0; m_fire = 0; m_pend = 0;
    end else begin
      m_fire = 0;
      launch = (m_act == 0) && t && (m_pend != 0 || s);
      if (m_act != 0) begin
        if (h) m_act = 0;
        else if (t) begin
          if (m_by < 4) m_act = 0;
          else m_by = m_by - 4;
        end
      end else if (launch) begin
        m_act = 1; m_bx = m_px + 16; m_by = 432; m_fire = 1; m_pend = 0;
      end else if (s) begin
        m_pend = 1;
      end
      if (t && l && !r) m_px = (m_px < 2) ? 0 : m_px - 2;
      if (t && r && !l) m_px = (m_px + 2 > 608) ? 608 : m_px + 2;
    end
    e.px = m_px; e.bx = m_bx; e.by = m_by; e.act = m_act; e.fire = m_fire;
    q.push_back(e);
  endtask

  // Monitor: compare one expectation per clock, just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("player_x", int'(player_x), e.px);
        chk("bullet_active", int'(bullet_active), e.act);
        chk("fire_evt", int'(fire_evt), e.fire);
        if (e.act != 0 || e.fire != 0) begin
          chk("bullet_x", int'(bullet_x), e.bx);
          chk("bullet_y", int'(bullet_y), e.by);
        end
      end
    end
  end

  initial begin
    int guard;
    #12;
    chk("rst_player_x", int'(player_x), 304);
    chk("rst_bullet_x", int'(bullet_x), 0);
    chk("rst_bullet_y", int'(bullet_y), 0);
    chk("rst_active", int'(bullet_active), 0);
    chk("rst_fire", int'(fire_evt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Hold right well past the clamp, ticks every other cycle
    for (int i = 0; i < 400; i++) begin
      cyc(1, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
    end
    // Hold left down to zero and beyond
    for (int i = 0; i < 320; i++) cyc(1, 1, 0, 0, 0, 0);
    // Both held: no motion
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 0, 0);

    // Back to centre, shoot mid-frame, then launching tick
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    // Fly to the top; a shoot during flight must not queue
    guard = 0;
    while (m_act != 0 && guard < 300) begin
      cyc(1, 0, 0, (guard == 50), 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      guard++;
    end
    chk("flight_ends", m_act, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);

    // Hit coincident with tick at bullet_y = 200
    cyc(1, 0, 0, 1, 0, 0);
    guard = 0;
    while (m_by != 200 && guard < 300) begin
      cyc(1, 1, 0, 0, 0, 0);
      guard++;
    end
    chk("reach_y200", m_by, 200);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // Hit while idle is ignored; launch then game_rst mid-flight
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0), ($urandom_range(0, 999) == 0));
    end

    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
